// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the execute-stage ALU
package alu_pkg;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0011;
  localparam logic [3:0] ALUOP_OR    = 4'b0100;
  localparam logic [3:0] ALUOP_SLT   = 4'b0101;
  localparam logic [3:0] ALUOP_LUI   = 4'b0110;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;

  typedef enum logic [3:0] {
    CTRL_AND     = 4'b0000,
    CTRL_OR      = 4'b0001,
    CTRL_ADD     = 4'b0010,
    CTRL_XOR     = 4'b0011,
    CTRL_SLTU    = 4'b0101,
    CTRL_SUB     = 4'b0110,
    CTRL_SLT     = 4'b0111,
    CTRL_SLL     = 4'b1000,
    CTRL_SRL     = 4'b1001,
    CTRL_SRA     = 4'b1010,
    CTRL_LUI     = 4'b1011,
    CTRL_NOR     = 4'b1100,
    CTRL_ADDU    = 4'b1101,
    CTRL_SUBU    = 4'b1110,
    CTRL_INVALID = 4'b1111
  } alu_ctrl_e;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/result bundle between the execute stage and the ALU
interface alu_if;

  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;

  modport master (
    output data1, data2, alu_op, funct, shamt, add_a, add_b,
    input  result, zero, overflow, add_sum
  );

  modport slave (
    input  data1, data2, alu_op, funct, shamt, add_a, add_b,
    output result, zero, overflow, add_sum
  );

endinterface

// File: rtl/alu_control_decode.sv
// rtl/alu_control_decode.sv - maps (alu_op, funct) to the internal ALU control code
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [3:0] alu_op_i,
  input  logic [5:0] funct_i,
  output alu_ctrl_e  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_INVALID;
    case (alu_op_i)
      ALUOP_ADD: ctrl_o = CTRL_ADD;
      ALUOP_SUB: ctrl_o = CTRL_SUB;
      ALUOP_AND: ctrl_o = CTRL_AND;
      ALUOP_OR:  ctrl_o = CTRL_OR;
      ALUOP_SLT: ctrl_o = CTRL_SLT;
      ALUOP_LUI: ctrl_o = CTRL_LUI;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD:  ctrl_o = CTRL_ADD;
          FUNCT_ADDU: ctrl_o = CTRL_ADDU;
          FUNCT_SUB:  ctrl_o = CTRL_SUB;
          FUNCT_SUBU: ctrl_o = CTRL_SUBU;
          FUNCT_AND:  ctrl_o = CTRL_AND;
          FUNCT_OR:   ctrl_o = CTRL_OR;
          FUNCT_XOR:  ctrl_o = CTRL_XOR;
          FUNCT_NOR:  ctrl_o = CTRL_NOR;
          FUNCT_SLT:  ctrl_o = CTRL_SLT;
          FUNCT_SLTU: ctrl_o = CTRL_SLTU;
          FUNCT_SLL:  ctrl_o = CTRL_SLL;
          FUNCT_SRL:  ctrl_o = CTRL_SRL;
          FUNCT_SRA:  ctrl_o = CTRL_SRA;
          default:    ctrl_o = CTRL_INVALID;
        endcase
      end
      default: ctrl_o = CTRL_INVALID;
    endcase
  end

endmodule

// File: rtl/alu_32bit.sv
// rtl/alu_32bit.sv - registered 32-bit execute ALU plus combinational PC/branch adder
module alu_32bit
  import alu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  alu_ctrl_e   ctrl;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        zero_q;

  alu_control_decode u_decode (
    .alu_op_i (bus.alu_op),
    .funct_i  (bus.funct),
    .ctrl_o   (ctrl)
  );

  assign sum  = bus.data1 + bus.data2;
  assign diff = bus.data1 - bus.data2;

  always_comb begin
    result_d   = 32'd0;
    overflow_d = 1'b0;
    case (ctrl)
      CTRL_ADD: begin
        result_d   = sum;
        overflow_d = (bus.data1[31] == bus.data2[31]) && (sum[31] != bus.data1[31]);
      end
      CTRL_SUB: begin
        result_d   = diff;
        overflow_d = (bus.data1[31] != bus.data2[31]) && (diff[31] != bus.data1[31]);
      end
      CTRL_ADDU: result_d = sum;
      CTRL_SUBU: result_d = diff;
      CTRL_AND:  result_d = bus.data1 & bus.data2;
      CTRL_OR:   result_d = bus.data1 | bus.data2;
      CTRL_XOR:  result_d = bus.data1 ^ bus.data2;
      CTRL_NOR:  result_d = ~(bus.data1 | bus.data2);
      CTRL_SLT:  result_d = {31'd0, $signed(bus.data1) < $signed(bus.data2)};
      CTRL_SLTU: result_d = {31'd0, bus.data1 < bus.data2};
      // Shifts operate on the rt operand only; data1 is ignored.
      CTRL_SLL:  result_d = bus.data2 << bus.shamt;
      CTRL_SRL:  result_d = bus.data2 >> bus.shamt;
      CTRL_SRA:  result_d = 32'($signed(bus.data2) >>> bus.shamt);
      CTRL_LUI:  result_d = {bus.data2[15:0], 16'h0000};
      default: begin
        result_d   = 32'd0;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= 32'd0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= (result_d == 32'd0);
      overflow_q <= overflow_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;

  assign bus.add_sum  = bus.add_a + bus.add_b;

endmodule

// File: tb/tb_alu_32bit.sv
// tb/tb_alu_32bit.sv - directed and randomized check of alu_32bit against an arithmetic model
module tb_alu_32bit;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  alu_if bus ();

  alu_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference behaviour from the instruction semantics, using 64-bit signed arithmetic
  function automatic void model(input logic [3:0] op, input logic [5:0] fn,
                                input logic [4:0] sh, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic ov);
    longint sa, sb, t;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    ov = 1'b0;
    case (op)
      4'd0: begin t = sa + sb; r = 32'(t); ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd1: begin t = sa - sb; r = 32'(t); ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = 32'((ub & 64'hFFFF) * 64'd65536);
      4'd2: begin
        case (fn)
          6'b100000: begin t = sa + sb; r = 32'(t); ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
          6'b100001: r = 32'(ua + ub);
          6'b100010: begin t = sa - sb; r = 32'(t); ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
          6'b100011: r = 32'(sa - sb);
          6'b100100: r = a & b;
          6'b100101: r = a | b;
          6'b100110: r = a ^ b;
          6'b100111: r = ~(a | b);
          6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
          6'b101011: r = (ua < ub) ? 32'd1 : 32'd0;
          6'b000000: r = 32'(ub << sh);
          6'b000010: r = 32'(ub >> sh);
          6'b000011: r = 32'(sb >>> sh);
          default:   r = 32'd0;
        endcase
      end
      default: r = 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [5:0] fn,
                     input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        eo;
    bus.alu_op = op;
    bus.funct  = fn;
    bus.shamt  = sh;
    bus.data1  = a;
    bus.data2  = b;
    @(posedge clk);
    #1;
    model(op, fn, sh, a, b, er, eo);
    chk({tag, ".result"},   bus.result, er);
    chk({tag, ".zero"},     {31'd0, bus.zero}, {31'd0, er == 32'd0});
    chk({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, eo});
  endtask

  logic [5:0]  fn_tab [13];
  logic [31:0] edge_tab [6];

  initial begin
    fn_tab = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
               6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011};
    edge_tab = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};

    reset = 1'b1;
    bus.data1 = 32'd5; bus.data2 = 32'd7; bus.alu_op = 4'b0000;
    bus.funct = 6'd0; bus.shamt = 5'd0; bus.add_a = 32'd0; bus.add_b = 32'd0;
    @(posedge clk);
    #1;
    chk("reset.result", bus.result, 32'd0);
    chk("reset.zero", {31'd0, bus.zero}, 32'd1);
    chk("reset.overflow", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;

    run("add_ovf", 4'b0010, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1);
    chk("add_ovf.const", bus.result, 32'h80000000);
    chk("add_ovf.flag", {31'd0, bus.overflow}, 32'd1);
    run("addu_noovf", 4'b0010, 6'b100001, 5'd0, 32'h7FFFFFFF, 32'h1);
    chk("addu_noovf.flag", {31'd0, bus.overflow}, 32'd0);
    run("beq_eq", 4'b0001, 6'd0, 5'd0, 32'h1234, 32'h1234);
    chk("beq_eq.zero", {31'd0, bus.zero}, 32'd1);
    run("beq_ne", 4'b0001, 6'd0, 5'd0, 32'h1234, 32'h1235);
    chk("beq_ne.const", bus.result, 32'hFFFFFFFF);
    run("slt", 4'b0010, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1);
    chk("slt.const", bus.result, 32'd1);
    run("sltu", 4'b0010, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1);
    chk("sltu.const", bus.result, 32'd0);
    run("sll", 4'b0010, 6'b000000, 5'd4, 32'hDEADBEEF, 32'h80000010);
    chk("sll.const", bus.result, 32'h00000100);
    run("srl", 4'b0010, 6'b000010, 5'd4, 32'h12345678, 32'h80000010);
    chk("srl.const", bus.result, 32'h08000001);
    run("sra", 4'b0010, 6'b000011, 5'd4, 32'h0, 32'h80000010);
    chk("sra.const", bus.result, 32'hF8000001);
    run("sra_sh0", 4'b0010, 6'b000011, 5'd0, 32'h0, 32'h80000010);
    chk("sra_sh0.const", bus.result, 32'h80000010);
    run("lui", 4'b0110, 6'd0, 5'd0, 32'h0, 32'h0000ABCD);
    chk("lui.const", bus.result, 32'hABCD0000);
    run("sub_ovf", 4'b0001, 6'd0, 5'd0, 32'h80000000, 32'h1);
    chk("sub_ovf.flag", {31'd0, bus.overflow}, 32'd1);
    run("bad_op", 4'b1001, 6'd0, 5'd0, 32'h5, 32'h7);
    chk("bad_op.zero", {31'd0, bus.zero}, 32'd1);
    run("bad_funct", 4'b0010, 6'b111111, 5'd0, 32'h5, 32'h7);

    bus.add_a = 32'hFFFFFFFC;
    bus.add_b = 32'd4;
    #1;
    chk("adder.wrap", bus.add_sum, 32'd0);

    // Reset arriving with a live operation must discard it
    bus.alu_op = 4'b0000; bus.data1 = 32'd3; bus.data2 = 32'd4;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset.result", bus.result, 32'd0);
    chk("midreset.zero", {31'd0, bus.zero}, 32'd1);
    reset = 1'b0;
    run("after_reset", 4'b0000, 6'd0, 5'd0, 32'd3, 32'd4);
    chk("after_reset.const", bus.result, 32'd7);

    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [5:0]  fn;
      logic [31:0] a, b, aa, ab;
      op = 4'($urandom_range(0, 9));
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 12)];
      a  = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      aa = $urandom;
      ab = $urandom;
      bus.add_a = aa;
      bus.add_b = ab;
      #1;
      chk($sformatf("rand%0d.add_sum", i), bus.add_sum, 32'(longint'(aa) + longint'(ab)));
      run($sformatf("rand%0d", i), op, fn, 5'($urandom), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
